// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART-driven debug bus initiator (frame parser, single bus transaction, response bytes)
//
// Purpose: parses READ (0x52) / WRITE (0x57) command frames from the UART
// receiver byte stream, runs one transaction on an arbiter initiator port,
// and returns a response byte sequence to the UART transmitter.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   rx_data/rx_valid    received byte + single-cycle strobe
//   tx_data/tx_valid    response byte, held until tx_ready
//   tx_ready            transmitter accepts on tx_valid && tx_ready
//   address_out         bus address (bits 63:32 always 0)
//   read_out/write_out  bus request strobes, held until ready_in
//   write_mask_out      write byte-lane mask
//   write_value_out     write data
//   read_value_in       read data, valid with ready_in
//   ready_in            transaction completes this cycle

module uart_bus_master #(
    parameter int BUS_TIMEOUT    = 1024,
    parameter int RX_GAP_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [63:0] address_out,
    output logic        read_out,
    output logic        write_out,
    output logic [3:0]  write_mask_out,
    output logic [63:0] write_value_out,
    input  logic [63:0] read_value_in,
    input  logic        ready_in
);

    localparam int BUS_W = $clog2(BUS_TIMEOUT);
    localparam int GAP_W = $clog2(RX_GAP_TIMEOUT + 1);
    localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_GAP_TIMEOUT - 1);

    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] RSP_BAD   = 8'h3F;
    localparam logic [7:0] RSP_WOK   = 8'h4B;
    localparam logic [7:0] RSP_ROK   = 8'h44;
    localparam logic [7:0] RSP_TMO   = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_MASK,
        S_BUS,
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_is_write;
    logic [3:0]        r_cnt;
    logic [3:0]        r_resp_last;
    logic [GAP_W-1:0]  r_gap;
    logic [BUS_W-1:0]  r_bus_cnt;
    logic [31:0]       r_addr;
    logic [63:0]       r_wdata;
    logic [3:0]        r_mask;
    logic [63:0]       r_shift;

    // Frame is abandoned when the idle-cycle count hits its limit with no byte this cycle.
    logic w_gap_expired;
    logic w_req_active;
    logic w_tx_fire;

    assign w_gap_expired = (r_gap == GAP_LAST) && !rx_valid;
    assign w_req_active  = read_out || write_out;
    assign w_tx_fire     = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_is_write      <= 1'b0;
            r_cnt           <= 4'd0;
            r_resp_last     <= 4'd0;
            r_gap           <= '0;
            r_bus_cnt       <= '0;
            r_addr          <= 32'd0;
            r_wdata         <= 64'd0;
            r_mask          <= 4'd0;
            r_shift         <= 64'd0;
            tx_data         <= 8'd0;
            tx_valid        <= 1'b0;
            address_out     <= 64'd0;
            read_out        <= 1'b0;
            write_out       <= 1'b0;
            write_mask_out  <= 4'd0;
            write_value_out <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_cnt <= 4'd0;
                        r_gap <= '0;
                        if (rx_data == OP_WRITE) begin
                            r_is_write <= 1'b1;
                            r_state    <= S_ADDR;
                        end else if (rx_data == OP_READ) begin
                            r_is_write <= 1'b0;
                            r_state    <= S_ADDR;
                        end else begin
                            tx_data     <= RSP_BAD;
                            tx_valid    <= 1'b1;
                            r_resp_last <= 4'd0;
                            r_state     <= S_RESP;
                        end
                    end
                end

                S_ADDR: begin
                    if (rx_valid) begin
                        r_addr <= {rx_data, r_addr[31:8]};   // little-endian shift-in
                        r_gap  <= '0;
                        if (r_cnt == 4'd3) begin
                            r_cnt     <= 4'd0;
                            r_bus_cnt <= '0;
                            r_state   <= r_is_write ? S_DATA : S_BUS;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else if (w_gap_expired) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        r_wdata <= {rx_data, r_wdata[63:8]};
                        r_gap   <= '0;
                        if (r_cnt == 4'd7) begin
                            r_cnt   <= 4'd0;
                            r_state <= S_MASK;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else if (w_gap_expired) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                S_MASK: begin
                    if (rx_valid) begin
                        r_mask    <= rx_data[3:0];
                        r_gap     <= '0;
                        r_cnt     <= 4'd0;
                        r_bus_cnt <= '0;
                        r_state   <= S_BUS;
                    end else if (w_gap_expired) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                S_BUS: begin
                    if (!w_req_active) begin
                        // First BUS cycle: launch the request with all qualifiers stable.
                        address_out     <= {32'd0, r_addr};
                        write_value_out <= r_is_write ? r_wdata : 64'd0;
                        write_mask_out  <= r_is_write ? r_mask : 4'd0;
                        read_out        <= !r_is_write;
                        write_out       <= r_is_write;
                        r_bus_cnt       <= '0;
                    end else if (ready_in) begin
                        read_out  <= 1'b0;
                        write_out <= 1'b0;
                        r_cnt     <= 4'd0;
                        tx_valid  <= 1'b1;
                        if (r_is_write) begin
                            tx_data     <= RSP_WOK;
                            r_resp_last <= 4'd0;
                        end else begin
                            tx_data     <= RSP_ROK;
                            r_shift     <= read_value_in;
                            r_resp_last <= 4'd8;
                        end
                        r_state <= S_RESP;
                    end else if (r_bus_cnt == BUS_LAST) begin
                        read_out    <= 1'b0;
                        write_out   <= 1'b0;
                        r_cnt       <= 4'd0;
                        tx_data     <= RSP_TMO;
                        tx_valid    <= 1'b1;
                        r_resp_last <= 4'd0;
                        r_state     <= S_RESP;
                    end else begin
                        r_bus_cnt <= r_bus_cnt + BUS_W'(1);
                    end
                end

                S_RESP: begin
                    if (w_tx_fire) begin
                        if (r_cnt == r_resp_last) begin
                            tx_valid <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_state  <= S_IDLE;
                        end else begin
                            // Read data bytes stream out LSB first from the capture register.
                            r_cnt   <= r_cnt + 4'd1;
                            tx_data <= r_shift[7:0];
                            r_shift <= {8'd0, r_shift[63:8]};
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - directed self-checking bench for uart_bus_master
module tb_uart_bus_master;

    localparam int BT = 8;
    localparam int GT = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [63:0] address_out;
    logic        read_out;
    logic        write_out;
    logic [3:0]  write_mask_out;
    logic [63:0] write_value_out;
    logic [63:0] read_value_in = 64'd0;
    logic        ready_in = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    uart_bus_master #(.BUS_TIMEOUT(BT), .RX_GAP_TIMEOUT(GT)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .address_out     (address_out),
        .read_out        (read_out),
        .write_out       (write_out),
        .write_mask_out  (write_mask_out),
        .write_value_out (write_value_out),
        .read_value_in   (read_value_in),
        .ready_in        (ready_in)
    );

    logic [7:0] txq[$];
    int         n_rd_hi = 0;
    int         n_wr_hi = 0;
    int         n_hold_bad = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'd0;

    always @(negedge clk) begin
        if (reset && tx_valid && tx_ready) txq.push_back(tx_data);
        if (read_out)  n_rd_hi++;
        if (write_out) n_wr_hi++;
        if (reset && hold_prev && (!tx_valid || tx_data !== hold_data)) n_hold_bad++;
        hold_prev = reset && tx_valid && !tx_ready;
        hold_data = tx_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_read_frame(input logic [31:0] a);
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    endtask

    task automatic wait_req(input bit wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr ? write_out : read_out) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_tx(input int base, input int n);
        for (int i = 0; i < 100; i++) begin
            if (txq.size() - base >= n) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic rd_txn(input logic [31:0] a, input logic [63:0] v, input bit bp);
        int   rb, qb, hb;
        bit   ok;
        logic [7:0] exp_b;
        logic [63:0] vv;
        rb = n_rd_hi;
        qb = txq.size();
        hb = n_hold_bad;
        vv = v;
        send_read_frame(a);
        wait_req(1'b0, ok);
        chk("rd_addr", address_out, {32'd0, a});
        @(posedge clk); #1;
        ready_in      = 1'b1;
        read_value_in = v;
        @(posedge clk); #1;
        ready_in      = 1'b0;
        read_value_in = 64'd0;
        for (int i = 0; i < 100; i++) begin
            if (txq.size() - qb >= 9) break;
            if (bp) tx_ready = ~tx_ready;
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rd_hi_cycles", 64'(n_rd_hi - rb), 64'd2);
        chk("rd_tx_count", 64'(txq.size() - qb), 64'd9);
        for (int i = 0; i < 9; i++) begin
            exp_b = (i == 0) ? 8'h44 : vv[8*(i-1) +: 8];
            chk($sformatf("rd_byte%0d", i), 64'(txq[qb + i]), 64'(exp_b));
        end
        chk("tx_hold_stable", 64'(n_hold_bad - hb), 64'd0);
    endtask

    initial begin
        int  qb, rb, wb;
        bit  ok;
        logic [7:0] wframe [14];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_read", 64'(read_out), 64'd0);
        chk("rst_write", 64'(write_out), 64'd0);
        chk("rst_addr", address_out, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Write 0xDEADBEEF to 0x00010000, mask 1, ready 3 cycles after request
        wframe = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        qb = txq.size();
        wb = n_wr_hi;
        for (int i = 0; i < 14; i++) send_byte(wframe[i]);
        wait_req(1'b1, ok);
        chk("wr_addr", address_out, 64'h0000_0000_0001_0000);
        chk("wr_value", write_value_out, 64'h0000_0000_DEAD_BEEF);
        chk("wr_mask", 64'(write_mask_out), 64'h1);
        chk("wr_no_read", 64'(read_out), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        wait_tx(qb, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("wr_hi_cycles", 64'(n_wr_hi - wb), 64'd3);
        chk("wr_tx_count", 64'(txq.size() - qb), 64'd1);
        chk("wr_resp", 64'(txq[qb]), 64'h4B);

        // Read from 0x4
        rd_txn(32'h0000_0004, 64'h0123_4567_89AB_CDEF, 1'b0);

        // Bus timeout: ready never comes
        qb = txq.size();
        rb = n_rd_hi;
        send_read_frame(32'h0005_0000);
        wait_req(1'b0, ok);
        chk("tmo_addr", address_out, 64'h0000_0000_0005_0000);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!read_out) break;
        end
        wait_tx(qb, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_rd_cycles", 64'(n_rd_hi - rb), 64'(BT));
        chk("tmo_tx_count", 64'(txq.size() - qb), 64'd1);
        chk("tmo_resp", 64'(txq[qb]), 64'hEE);
        rd_txn(32'h0000_0008, 64'h1122_3344_5566_7788, 1'b0);

        // Bad opcode
        qb = txq.size();
        send_byte(8'h99);
        wait_tx(qb, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("bad_tx_count", 64'(txq.size() - qb), 64'd1);
        chk("bad_resp", 64'(txq[qb]), 64'h3F);

        // Partial frame then rx gap: silently dropped
        qb = txq.size();
        rb = n_rd_hi;
        wb = n_wr_hi;
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (GT + 1) @(posedge clk);
        #1;
        chk("gap_no_bus", 64'((n_rd_hi - rb) + (n_wr_hi - wb)), 64'd0);
        chk("gap_no_tx", 64'(txq.size() - qb), 64'd0);
        rd_txn(32'h0000_0010, 64'hA5A5_0000_FFFF_5A5A, 1'b0);

        // Backpressure on the read response
        rd_txn(32'h0000_0020, 64'hFEDC_BA98_7654_3210, 1'b1);

        // Async reset in the middle of a write DATA phase
        qb = txq.size();
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(8'h11);
        for (int i = 0; i < 3; i++) send_byte(8'h22);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("arst_data_txv", 64'(tx_valid), 64'd0);
        chk("arst_data_wr", 64'(write_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        rb = n_rd_hi;
        wb = n_wr_hi;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_data_no_tx", 64'(txq.size() - qb), 64'd0);
        chk("arst_data_no_bus", 64'((n_rd_hi - rb) + (n_wr_hi - wb)), 64'd0);

        // Async reset while read_out is asserted
        qb = txq.size();
        send_read_frame(32'h0003_0000);
        wait_req(1'b0, ok);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_bus_rd", 64'(read_out), 64'd0);
        chk("arst_bus_addr", address_out, 64'd0);
        chk("arst_bus_txv", 64'(tx_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        rb = n_rd_hi;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_bus_no_tx", 64'(txq.size() - qb), 64'd0);
        chk("arst_bus_no_rd", 64'(n_rd_hi - rb), 64'd0);
        rd_txn(32'h0000_0030, 64'h0000_0000_0000_00C3, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Bus initiator driven by a byte stream from the UART receiver. It is the debug/loader path into the same memory map the CPU reaches through the bus arbiter.
- Parses command frames, issues single read or write transactions on an arbiter initiator port, and returns response bytes to the UART transmitter.
- Loads RAM, peeks/pokes LEDs, UART and timer registers with no CPU involvement.

Parameters:
- BUS_TIMEOUT, 1024, max cycles to wait for ready_in before aborting a transaction (>=2).
- RX_GAP_TIMEOUT, 65535, max idle cycles between bytes inside one frame before the frame is discarded.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rx_data  input  8  received byte
- rx_valid  input  1  single-cycle strobe; rx_data valid
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  transmitter accepts byte when tx_valid&&tx_ready
- address_out  output  64  bus address; bits 63:32 always 0
- read_out  output  1  bus read request
- write_out  output  1  bus write request
- write_mask_out  output  4  write byte-lane mask
- write_value_out  output  64  write data
- read_value_in  input  64  read data, valid when ready_in
- ready_in  input  1  transaction complete this cycle

Behaviour:
- Reset (reset=0, async): state IDLE; tx_valid=0, tx_data=0, read_out=0, write_out=0, address_out=0, write_mask_out=0, write_value_out=0; all counters cleared. Any in-flight frame or transaction is dropped; no response is sent.
- Frames (multi-byte fields little-endian):
  - WRITE: 0x57, addr[31:0] (4 bytes), data[63:0] (8 bytes), mask (1 byte, bits 3:0 used). 14 bytes total.
  - READ: 0x52, addr[31:0] (4 bytes). 5 bytes total.
- States: IDLE, ADDR, DATA, MASK, BUS, RESP.
- IDLE:
  - 0x57 -> ADDR (write).
  - 0x52 -> ADDR (read).
  - Any other byte -> RESP with single byte 0x3F.
- ADDR collects 4 bytes, then goes to DATA for a write or BUS for a read.
- DATA collects 8 bytes, then MASK. MASK takes 1 byte, then BUS.
- BUS:
  - read_out or write_out asserts on the cycle after entering BUS. address_out, mask and value are stable from that cycle on.
  - The request holds until the first cycle with ready_in=1. Requests deassert the next cycle.
  - read_value_in is captured on the ready cycle.
  - ready_in is ignored when no request is asserted.
- Bus timeout: if ready_in is not seen within BUS_TIMEOUT cycles of request assertion, drop the request and go to RESP with 0xEE.
- RESP:
  - Write success sends 0x4B.
  - Read success sends 0x44 followed by 8 data bytes, LSB first (9 bytes).
  - tx_data/tx_valid are registered; a byte advances only on tx_valid&&tx_ready. After the last byte is accepted, return to IDLE.
  - rx_valid bytes arriving in BUS or RESP are discarded.
- rx gap: in ADDR/DATA/MASK, RX_GAP_TIMEOUT cycles with no rx_valid discards the frame and returns to IDLE silently. The counter clears on each accepted byte.
- Byte counters are 4-bit and reset on every state entry. No wrap within a frame.
- tx_ready may be held high. Each byte is still presented for at least 1 cycle, and tx_valid may stay high back-to-back across bytes.

Test Plan:
- Write: bytes 57 00 00 01 00 EF BE AD DE 00 00 00 00 01. Bus responder gives ready 3 cycles later. Expected: write_out=1 with address_out=0x10000, write_value_out=0xDEADBEEF, write_mask_out=0x1 until ready; then tx sends 0x4B.
- Read: bytes 52 04 00 00 00. Responder returns 0x0123456789ABCDEF with ready 1 cycle after read_out. Expected tx: 44 EF CD AB 89 67 45 23 01. read_out is high exactly 2 cycles.
- Timeout: BUS_TIMEOUT=8, read to 0x00050000, ready_in held 0. Expected: read_out drops after 8 cycles; tx sends 0xEE; a following valid READ succeeds.
- Bad opcode and gap: byte 0x99 -> tx 0x3F. Then 0x57, 2 addr bytes, and silence for RX_GAP_TIMEOUT+1 cycles -> no bus activity and no tx; next READ frame decodes correctly.
- Backpressure: during read response, tx_ready toggles 1/0 every cycle. Expected: all 9 bytes delivered in order with no duplicates, and tx_data stable while tx_valid&&!tx_ready.
- Async reset: assert reset low mid-DATA, and separately while read_out=1. Expected: all outputs 0 immediately, without waiting for a clk edge; no response emitted after release.
